regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/cpu_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 59 +++++
 rtl/regfile_wb_arbiter.sv | 103 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the writeback arbiter and scoreboard.
// Holds datapath widths and the writeback requester identifiers.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    // Writeback requesters; also the encoding of the priority pointer.
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Register busy-bit scoreboard: issue-time hazard stall, busy set on
// issue and busy clear on writeback commit.
module regfile_scoreboard #(
    parameter int AW = cpu_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid,
    input  logic          issue_has_rd,
    input  logic [AW-1:0] issue_rd,
    input  logic [AW-1:0] src1_addr,
    input  logic [AW-1:0] src2_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    output logic          stall,
    output logic          clr_busy
);

    localparam int NREG = 1 << AW;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            set_en;

    // Stall only looks at registered busy bits; a commit this cycle
    // does not release a dependent until the next cycle.
    assign stall = issue_valid
                 & (busy_q[src1_addr]
                 |  busy_q[src2_addr]
                 | (issue_has_rd & busy_q[issue_rd]));

    assign set_en = issue_valid & ~stall & issue_has_rd
                  & (issue_rd != '0);

    // Busy state of the register being committed, for error detection.
    assign clr_busy = busy_q[clr_addr];

    // Next busy vector: clear on commit, set on issue, x0 never busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy-bit storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-requester (ALU/LSU) writeback arbiter with registered
// register-file write port and scoreboard-based issue stall.
module regfile_wb_arbiter #(
    parameter int XLEN = cpu_pkg::XLEN,
    parameter int AW   = cpu_pkg::AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    output logic            rd_write_enb,
    output logic [AW-1:0]   rd_address,
    output logic [XLEN-1:0] rd_data_in,
    input  logic            issue_valid,
    input  logic            issue_has_rd,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   src1_addr,
    input  logic [AW-1:0]   src2_addr,
    output logic            stall,
    output logic            wb_err
);

    import cpu_pkg::*;

    req_e            prio_q;
    logic            alu_gnt;
    logic            lsu_gnt;
    logic            hs;
    logic            hs_wr;
    logic [AW-1:0]   hs_rd;
    logic [XLEN-1:0] hs_data;
    logic            clr_busy;

    // Grant: lone requester wins, contention resolved by the pointer.
    always_comb begin
        alu_gnt = alu_valid & (~lsu_valid | (prio_q == REQ_ALU));
        lsu_gnt = lsu_valid & ~alu_gnt;
    end

    assign alu_ready = alu_gnt;
    assign lsu_ready = lsu_gnt;

    assign hs      = alu_gnt | lsu_gnt;
    assign hs_rd   = alu_gnt ? alu_rd   : lsu_rd;
    assign hs_data = alu_gnt ? alu_data : lsu_data;
    assign hs_wr   = hs & (hs_rd != '0);

    // Priority pointer moves to the loser only after real contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= REQ_ALU;
        end else if (alu_valid & lsu_valid) begin
            prio_q <= alu_gnt ? REQ_LSU : REQ_ALU;
        end
    end

    // Registered write port; x0 writes are consumed but never strobed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_write_enb <= 1'b0;
            rd_address   <= '0;
            rd_data_in   <= '0;
        end else begin
            rd_write_enb <= hs_wr;
            if (hs_wr) begin
                rd_address <= hs_rd;
                rd_data_in <= hs_data;
            end
        end
    end

    // Sticky flag for a commit to a register nobody marked busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_err <= 1'b0;
        end else if (rd_write_enb & ~clr_busy) begin
            wb_err <= 1'b1;
        end
    end

    regfile_scoreboard #(
        .AW(AW)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_has_rd (issue_has_rd),
        .issue_rd     (issue_rd),
        .src1_addr    (src1_addr),
        .src2_addr    (src2_addr),
        .clr_en       (rd_write_enb),
        .clr_addr     (rd_address),
        .stall        (stall),
        .clr_busy     (clr_busy)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
// Inputs change 1ns after posedge; outputs sampled 1ns later.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        rd_write_enb;
    logic [4:0]  rd_address;
    logic [31:0] rd_data_in;
    logic        issue_valid;
    logic        issue_has_rd;
    logic [4:0]  issue_rd;
    logic [4:0]  src1_addr;
    logic [4:0]  src2_addr;
    logic        stall;
    logic        wb_err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .XLEN(32),
        .AW  (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .lsu_valid    (lsu_valid),
        .lsu_rd       (lsu_rd),
        .lsu_data     (lsu_data),
        .lsu_ready    (lsu_ready),
        .rd_write_enb (rd_write_enb),
        .rd_address   (rd_address),
        .rd_data_in   (rd_data_in),
        .issue_valid  (issue_valid),
        .issue_has_rd (issue_has_rd),
        .issue_rd     (issue_rd),
        .src1_addr    (src1_addr),
        .src2_addr    (src2_addr),
        .stall        (stall),
        .wb_err       (wb_err)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input logic v, input logic h, input logic [4:0] rd,
                         input logic [4:0] s1, input logic [4:0] s2);
        issue_valid  = v;
        issue_has_rd = h;
        issue_rd     = rd;
        src1_addr    = s1;
        src2_addr    = s2;
    endtask

    initial begin
        rst       = 1'b1;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

        // reset
        cyc(); cyc();
        rst = 1'b0;
        issue(1'b1, 1'b0, 5'd0, 5'd5, 5'd0);
        settle();
        chk("rst_wen",   rd_write_enb, 0);
        chk("rst_addr",  rd_address, 0);
        chk("rst_data",  rd_data_in, 0);
        chk("rst_err",   wb_err, 0);
        chk("rst_ready", {alu_ready, lsu_ready}, 2'b00);
        chk("rst_stall", stall, 0);

        // ALU write to r5 after issuing r5
        cyc(); issue(1'b1, 1'b1, 5'd5, 5'd0, 5'd0); settle();
        chk("iss5_stall", stall, 0);
        cyc(); issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        settle();
        chk("alu_gnt", {alu_ready, lsu_ready}, 2'b10);
        chk("alu_wen_pre", rd_write_enb, 0);
        cyc(); alu_valid = 1'b0;
        issue(1'b1, 1'b0, 5'd0, 5'd5, 5'd0); settle();
        chk("wb5_wen",  rd_write_enb, 1);
        chk("wb5_addr", rd_address, 5);
        chk("wb5_data", rd_data_in, 32'hDEADBEEF);
        chk("wb5_stall", stall, 1);
        cyc(); settle();
        chk("r5_free",   stall, 0);
        chk("idle_wen",  rd_write_enb, 0);
        chk("hold_addr", rd_address, 5);
        chk("hold_data", rd_data_in, 32'hDEADBEEF);
        cyc(); issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0); settle();
        chk("wb5_noerr", wb_err, 0);

        // RAW on r7 through an LSU writeback
        cyc(); issue(1'b1, 1'b1, 5'd7, 5'd0, 5'd0); settle();
        chk("iss7_stall", stall, 0);
        cyc(); issue(1'b1, 1'b1, 5'd7, 5'd0, 5'd0); settle();
        chk("waw7_stall", stall, 1);
        cyc(); issue(1'b1, 1'b0, 5'd0, 5'd7, 5'd0);
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h0000_0777;
        settle();
        chk("raw7_stall", stall, 1);
        chk("lsu_gnt", {alu_ready, lsu_ready}, 2'b01);
        cyc(); lsu_valid = 1'b0;
        issue(1'b1, 1'b1, 5'd10, 5'd0, 5'd0); settle();
        chk("wb7_wen",  rd_write_enb, 1);
        chk("wb7_addr", rd_address, 7);
        chk("wb7_data", rd_data_in, 32'h777);
        chk("iss10_stall", stall, 0);
        cyc(); issue(1'b1, 1'b0, 5'd0, 5'd7, 5'd0); settle();
        chk("r7_free", stall, 0);
        cyc(); issue(1'b1, 1'b0, 5'd0, 5'd0, 5'd10); settle();
        chk("r10_busy", stall, 1);
        cyc(); issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0); settle();
        chk("r7_noerr", wb_err, 0);

        // round-robin on contention, rd=0 both sides
        cyc();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1111;
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h2222;
        settle();
        chk("rr1", {alu_ready, lsu_ready}, 2'b10);
        cyc(); settle();
        chk("rr2", {alu_ready, lsu_ready}, 2'b01);
        chk("x0_nowen_a", rd_write_enb, 0);
        cyc(); settle();
        chk("rr3", {alu_ready, lsu_ready}, 2'b10);
        chk("x0_nowen_l", rd_write_enb, 0);
        cyc(); settle();
        chk("rr4", {alu_ready, lsu_ready}, 2'b01);
        cyc(); alu_valid = 1'b0; settle();
        chk("lsu_only", {alu_ready, lsu_ready}, 2'b01);
        cyc(); alu_valid = 1'b1; settle();
        chk("ptr_kept", {alu_ready, lsu_ready}, 2'b10);
        cyc(); alu_valid = 1'b0; lsu_valid = 1'b0; settle();
        chk("x0_nowen", rd_write_enb, 0);
        chk("x0_noerr", wb_err, 0);

        // commit to non-busy r9 -> sticky error
        cyc(); alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        settle();
        chk("alu9_gnt", {alu_ready, lsu_ready}, 2'b10);
        cyc(); alu_valid = 1'b0; settle();
        chk("wb9_addr", rd_address, 9);
        chk("err_pre", wb_err, 0);
        cyc(); settle();
        chk("err_set", wb_err, 1);
        cyc(); issue(1'b1, 1'b1, 5'd12, 5'd0, 5'd0); settle();
        chk("iss12_stall", stall, 0);
        chk("err_hold", wb_err, 1);

        // reset during ALU handshake (pointer currently LSU)
        cyc(); issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        rst = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        settle();
        chk("rst_alu_gnt", {alu_ready, lsu_ready}, 2'b10);
        cyc(); rst = 1'b0; alu_valid = 1'b0;
        issue(1'b1, 1'b0, 5'd0, 5'd12, 5'd10); settle();
        chk("rhs_wen",   rd_write_enb, 0);
        chk("rhs_addr",  rd_address, 0);
        chk("rhs_data",  rd_data_in, 0);
        chk("rhs_err",   wb_err, 0);
        chk("rhs_busy",  stall, 0);
        cyc(); issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        alu_valid = 1'b1; alu_rd = 5'd0;
        lsu_valid = 1'b1; lsu_rd = 5'd0;
        settle();
        chk("rhs_prio", {alu_ready, lsu_ready}, 2'b10);
        cyc(); alu_valid = 1'b0; lsu_valid = 1'b0; settle();
        chk("end_wen", rd_write_enb, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
